snake_frame_renderer: RTL and testbench

Downstream display stage of the Snake datapath. On a `start` request it walks the snake body RAM (addresses 0..size-1) through a synchronous 1-cycle-latency read port and rasterises the segments into an 8x8 back buffer. It then adds the apple and swaps the result into a front buffer. The front buffer is continuously row-scanned onto an 8x8 LED matrix, and the apple pixel blinks.

---
 rtl/snake_frame_renderer.sv | 104 ++++++++++
 tb/tb_snake_frame_renderer.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/snake_frame_renderer.sv
// snake_frame_renderer: rasterises snake body RAM plus apple into a double-buffered 8x8 row-scanned LED matrix
module snake_frame_renderer #(
  parameter int ROW_TICKS = 50000,
  parameter int BLINK_TICKS = 12500000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] size,
  input  logic [5:0] apple,
  input  logic       apple_en,
  output logic [5:0] rd_addr,
  input  logic [5:0] rd_data,
  output logic       busy,
  output logic       done,
  output logic [7:0] row_sel,
  output logic [7:0] col_data,
  output logic [2:0] db_state
);
  localparam int RW = $clog2(ROW_TICKS);
  localparam int BW = $clog2(BLINK_TICKS);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROW_TICKS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    APPLE = 3'd4,
    SWAP  = 3'd5
  } state_t;
  state_t state, next;
  logic [5:0] cnt, size_r, apple_b, apple_f;
  logic apple_bv, apple_fv, vld, blink;
  logic [63:0] back, front;
  logic [RW-1:0] row_tick;
  logic [BW-1:0] blink_tick;
  logic [2:0] row;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = start ? CLEAR : IDLE;
      CLEAR:   next = size != 6'd0 ? READ : APPLE;
      READ:    next = cnt == size_r - 6'd1 ? DRAIN : READ;
      DRAIN:   next = APPLE;
      APPLE:   next = SWAP;
      SWAP:    next = IDLE;
      default: next = IDLE;
    endcase
  end
  assign rd_addr = state == READ ? cnt : 6'd0;
  assign busy = state != IDLE;
  assign done = state == SWAP;
  assign db_state = state;
  // vld trails READ by one cycle to match the RAM read latency, so DRAIN catches the last word
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt <= 6'd0;
      size_r <= 6'd0;
      vld <= 1'b0;
      back <= 64'd0;
      front <= 64'd0;
      apple_b <= 6'd0;
      apple_bv <= 1'b0;
      apple_f <= 6'd0;
      apple_fv <= 1'b0;
    end else begin
      state <= next;
      vld <= state == READ;
      if (state == CLEAR) begin
        back <= 64'd0;
        cnt <= 6'd0;
        size_r <= size;
      end else if (vld) back[rd_data] <= 1'b1;
      if (state == READ) cnt <= cnt + 6'd1;
      if (state == APPLE) begin
        apple_b <= apple;
        apple_bv <= apple_en;
      end
      if (state == SWAP) begin
        front <= back;
        apple_f <= apple_b;
        apple_fv <= apple_bv;
      end
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      row_tick <= '0;
      row <= 3'd0;
      blink_tick <= '0;
      blink <= 1'b0;
    end else begin
      row_tick <= row_tick == ROW_LAST ? '0 : row_tick + 1'b1;
      if (row_tick == ROW_LAST) row <= row + 3'd1;
      blink_tick <= blink_tick == BLINK_LAST ? '0 : blink_tick + 1'b1;
      if (blink_tick == BLINK_LAST) blink <= ~blink;
    end
  end
  assign row_sel = 8'd1 << row;
  assign col_data = front[{row, 3'b000} +: 8] |
                    ((apple_fv && apple_f[5:3] == row && blink) ? 8'd1 << apple_f[2:0] : 8'd0);
endmodule

// File: tb/tb_snake_frame_renderer.sv
// tb_snake_frame_renderer: directed checks of frame build latency, buffering, scan and blink
module tb_snake_frame_renderer;
  logic clock = 1'b0, reset = 1'b1, start = 1'b0, apple_en = 1'b0, busy, done;
  logic [5:0] size = 6'd0, apple = 6'd0, rd_addr, rd_data;
  logic [7:0] row_sel, col_data, prev;
  logic [2:0] db_state;
  logic [5:0] mem [64];
  int checks = 0, errors = 0;
  snake_frame_renderer #(.ROW_TICKS(4), .BLINK_TICKS(64)) dut (
    .clock(clock), .reset(reset), .start(start), .size(size), .apple(apple),
    .apple_en(apple_en), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy),
    .done(done), .row_sel(row_sel), .col_data(col_data), .db_state(db_state)
  );
  always #5 clock = ~clock;
  always @(posedge clock) rd_data <= mem[rd_addr];
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic frame(input logic [5:0] sz, input logic [5:0] ap, input logic en, input int lat);
    size = sz;
    apple = ap;
    apple_en = en;
    start = 1'b1;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clock);
      start = 1'b0;
      if (k >= 2 && k < 2 + int'(sz)) check("rd_addr", rd_addr, 64'(k - 2));
      if (k == lat - 1) check("pre_done", done, 0);
      if (k == lat) check("done", done, 1);
    end
  endtask
  task automatic wait_row(input int r);
    int n = 0;
    while (row_sel != (8'd1 << r) && n < 64) begin
      @(negedge clock);
      n++;
    end
    check("row_reach", row_sel, 8'd1 << r);
  endtask
  initial begin
    int on, off, bad, seen, dn;
    foreach (mem[i]) mem[i] = 6'd0;
    mem[0] = 6'o33;
    mem[1] = 6'o32;
    mem[2] = 6'o31;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("rst_row", row_sel, 8'h01);
    check("rst_col", col_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_state", db_state, 0);
    check("rst_addr", rd_addr, 0);
    for (int i = 1; i <= 8; i++) begin
      repeat (4) @(negedge clock);
      check("row_seq", row_sel, 8'd1 << (i % 8));
    end
    // body only: three segments on row 3
    frame(6'd3, 6'd0, 1'b0, 7);
    wait_row(3);
    check("t2_row3", col_data, 8'h0E);
    wait_row(0);
    check("t2_row0", col_data, 0);
    wait_row(6);
    check("t2_row6", col_data, 0);
    // no body, blinking apple at row 5 col 5
    frame(6'd0, 6'o55, 1'b1, 3);
    on = 0; off = 0; bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (row_sel == 8'h20) begin
        if (col_data == 8'h00) off++;
        else if (col_data == 8'h20) on++;
        else bad++;
      end else if (col_data != 8'h00) bad++;
    end
    check("t3_on", on > 0, 1);
    check("t3_off", off > 0, 1);
    check("t3_bad", bad, 0);
    // apple on a body pixel stays lit in both phases
    frame(6'd3, 6'o33, 1'b1, 7);
    bad = 0; seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (row_sel == 8'h08) begin
        seen++;
        if (col_data != 8'h0E) bad++;
      end
    end
    check("t4_seen", seen > 0, 1);
    check("t4_bad", bad, 0);
    // align start to the first cycle of row 2 so row 3 shows during the build
    prev = row_sel;
    @(negedge clock);
    for (int n = 0; n < 64 && !(row_sel == 8'h04 && prev == 8'h02); n++) begin
      prev = row_sel;
      @(negedge clock);
    end
    check("t5_align", row_sel, 8'h04);
    size = 6'd1;
    apple_en = 1'b0;
    start = 1'b1;
    dn = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clock);
      start = k == 2;
      if (done) dn++;
      if (k == 2) check("t5_read", db_state, 2);
      if (k == 4) begin
        check("t5_busy", busy, 1);
        check("t5_row", row_sel, 8'h08);
        check("t5_old", col_data, 8'h0E);
      end
      if (k == 5) begin
        check("t5_done", done, 1);
        check("t5_old2", col_data, 8'h0E);
      end
      if (k == 6) check("t5_new", col_data, 8'h08);
    end
    check("t5_dones", dn, 1);
    // reset during READ
    size = 6'd3;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    check("t6_read", db_state, 2);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("t6_busy", busy, 0);
    check("t6_state", db_state, 0);
    check("t6_col", col_data, 0);
    check("t6_rowsel", row_sel, 8'h01);
    reset = 1'b0;
    frame(6'd3, 6'd0, 1'b0, 7);
    wait_row(3);
    check("t6_row3", col_data, 8'h0E);
    wait_row(2);
    check("t6_row2", col_data, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
